// File: rtl/dist_scan_queue.sv
// Dijkstra distance store and min-priority queue: per-node distance and visited bit,
// served by INIT / RELAX / READ commands and a LANES-wide multi-cycle POP_MIN scan.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_VALUE_WIDTH
`define DEFAULT_VALUE_WIDTH 16
`endif

module dist_scan_queue #(
  parameter int MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = `DEFAULT_VALUE_WIDTH,
  parameter int LANES       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [INDEX_WIDTH-1:0] cmd_index,
  input  logic [VALUE_WIDTH-1:0] cmd_value,
  output logic                   rsp_valid,
  output logic [INDEX_WIDTH-1:0] rsp_index,
  output logic [VALUE_WIDTH-1:0] rsp_value,
  output logic                   rsp_updated,
  output logic                   rsp_empty,
  output logic [INDEX_WIDTH:0]   visited_count
);

  localparam int S  = (MAX_NODES + LANES - 1) / LANES;
  localparam int CW = (S > 1) ? $clog2(S) : 1;
  localparam logic [1:0] OP_INIT  = 2'b00;
  localparam logic [1:0] OP_RELAX = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [VALUE_WIDTH-1:0] INF = {VALUE_WIDTH{1'b1}};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESP = 2'd1, ST_SCAN = 2'd2} state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [VALUE_WIDTH-1:0] r_dist [MAX_NODES];
  logic [MAX_NODES-1:0]   r_visited;
  logic [INDEX_WIDTH:0]   r_visited_count;
  logic [CW-1:0]          r_chunk;
  logic                   r_best_found;
  logic [INDEX_WIDTH-1:0] r_best_idx;
  logic [VALUE_WIDTH-1:0] r_best_val;
  logic                   r_cmd_ready;
  logic                   r_rsp_valid;
  logic [INDEX_WIDTH-1:0] r_rsp_index;
  logic [VALUE_WIDTH-1:0] r_rsp_value;
  logic                   r_rsp_updated;
  logic                   r_rsp_empty;

  logic                   w_accept;
  logic                   w_last;
  logic                   w_sel_hit;
  logic                   w_sel_vis;
  logic [VALUE_WIDTH-1:0] w_sel_dist;
  logic                   w_relax_upd;
  logic                   w_best_found;
  logic [INDEX_WIDTH-1:0] w_best_idx;
  logic [VALUE_WIDTH-1:0] w_best_val;

  assign w_accept    = cmd_valid & r_cmd_ready;
  assign w_last      = (r_chunk == CW'(S - 1));
  assign w_relax_upd = w_sel_hit & ~w_sel_vis & (cmd_value < w_sel_dist);

  // Addressed-node lookup; an out-of-range index misses and reads as INFINITY.
  always_comb begin
    w_sel_hit  = 1'b0;
    w_sel_vis  = 1'b0;
    w_sel_dist = INF;
    for (int n = 0; n < MAX_NODES; n++) begin
      if (cmd_index == INDEX_WIDTH'(n)) begin
        w_sel_hit  = 1'b1;
        w_sel_vis  = r_visited[n];
        w_sel_dist = r_dist[n];
      end else begin
        w_sel_hit  = w_sel_hit;
      end
    end
  end

  // Fold the current chunk into the running best; strict '<' in ascending order keeps the lowest index on ties.
  always_comb begin
    w_best_found = r_best_found;
    w_best_idx   = r_best_idx;
    w_best_val   = r_best_val;
    for (int n = 0; n < MAX_NODES; n++) begin
      if ((CW'(n / LANES) == r_chunk) && !r_visited[n] && (r_dist[n] != INF) &&
          (!w_best_found || (r_dist[n] < w_best_val))) begin
        w_best_found = 1'b1;
        w_best_idx   = INDEX_WIDTH'(n);
        w_best_val   = r_dist[n];
      end else begin
        w_best_found = w_best_found;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = (cmd_op == 2'b11) ? ST_SCAN : ST_RESP;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SCAN: w_next_state = w_last ? ST_RESP : ST_SCAN;
      ST_RESP: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register, node storage and registered response.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_cmd_ready     <= 1'b0;
      r_visited       <= '0;
      r_visited_count <= '0;
      r_chunk         <= '0;
      r_best_found    <= 1'b0;
      r_best_idx      <= '0;
      r_best_val      <= INF;
      r_rsp_valid     <= 1'b0;
      r_rsp_index     <= '0;
      r_rsp_value     <= '0;
      r_rsp_updated   <= 1'b0;
      r_rsp_empty     <= 1'b0;
      for (int n = 0; n < MAX_NODES; n++) r_dist[n] <= INF;
    end else begin
      r_state     <= w_next_state;
      r_cmd_ready <= (w_next_state == ST_IDLE);
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_chunk       <= '0;
            r_best_found  <= 1'b0;
            r_best_idx    <= '0;
            r_best_val    <= INF;
            r_rsp_index   <= cmd_index;
            r_rsp_updated <= 1'b0;
            r_rsp_empty   <= 1'b0;
            case (cmd_op)
              OP_INIT: begin
                r_rsp_valid     <= 1'b1;
                r_rsp_value     <= '0;
                r_visited       <= '0;
                r_visited_count <= '0;
                for (int n = 0; n < MAX_NODES; n++) begin
                  r_dist[n] <= (cmd_index == INDEX_WIDTH'(n)) ? '0 : INF;
                end
              end
              OP_RELAX: begin
                r_rsp_valid   <= 1'b1;
                r_rsp_updated <= w_relax_upd;
                r_rsp_value   <= w_relax_upd ? cmd_value : w_sel_dist;
                for (int n = 0; n < MAX_NODES; n++) begin
                  if (w_relax_upd && (cmd_index == INDEX_WIDTH'(n))) r_dist[n] <= cmd_value;
                end
              end
              OP_READ: begin
                r_rsp_valid <= 1'b1;
                r_rsp_value <= w_sel_dist;
              end
              default: r_rsp_valid <= 1'b0;
            endcase
          end
        end
        ST_SCAN: begin
          r_chunk      <= r_chunk + CW'(1);
          r_best_found <= w_best_found;
          r_best_idx   <= w_best_idx;
          r_best_val   <= w_best_val;
          if (w_last) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_updated <= 1'b0;
            if (w_best_found) begin
              r_rsp_empty     <= 1'b0;
              r_rsp_index     <= w_best_idx;
              r_rsp_value     <= w_best_val;
              r_visited_count <= r_visited_count + (INDEX_WIDTH + 1)'(1);
              for (int n = 0; n < MAX_NODES; n++) begin
                if (w_best_idx == INDEX_WIDTH'(n)) r_visited[n] <= 1'b1;
              end
            end else begin
              r_rsp_empty <= 1'b1;
              r_rsp_index <= '0;
              r_rsp_value <= INF;
            end
          end
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_index     = r_rsp_index;
  assign rsp_value     = r_rsp_value;
  assign rsp_updated   = r_rsp_updated;
  assign rsp_empty     = r_rsp_empty;
  assign visited_count = r_visited_count;

endmodule

// File: tb/tb_dist_scan_queue.sv
// Directed bench for dist_scan_queue: unit 0 is MAX_NODES=8/LANES=2, unit 1 is MAX_NODES=7/LANES=3.
module tb_dist_scan_queue;

  logic        clock = 1'b0;
  logic        reset [2];
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [1:0]  cmd_op [2];
  logic [3:0]  cmd_index [2];
  logic [15:0] cmd_value [2];
  logic        rsp_valid [2];
  logic [3:0]  rsp_index [2];
  logic [15:0] rsp_value [2];
  logic        rsp_updated [2];
  logic        rsp_empty [2];
  logic [4:0]  visited_count [2];

  int checks = 0;
  int errors = 0;
  int g_lat;
  int g_got;
  logic [3:0]  g_idx;
  logic [15:0] g_val;
  logic        g_upd;
  logic        g_empty;

  always #5 clock = ~clock;

  dist_scan_queue #(.MAX_NODES(8), .INDEX_WIDTH(4), .VALUE_WIDTH(16), .LANES(2)) u_a (
    .clock(clock), .reset(reset[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_index(cmd_index[0]), .cmd_value(cmd_value[0]),
    .rsp_valid(rsp_valid[0]), .rsp_index(rsp_index[0]), .rsp_value(rsp_value[0]),
    .rsp_updated(rsp_updated[0]), .rsp_empty(rsp_empty[0]), .visited_count(visited_count[0]));

  dist_scan_queue #(.MAX_NODES(7), .INDEX_WIDTH(4), .VALUE_WIDTH(16), .LANES(3)) u_b (
    .clock(clock), .reset(reset[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_index(cmd_index[1]), .cmd_value(cmd_value[1]),
    .rsp_valid(rsp_valid[1]), .rsp_index(rsp_index[1]), .rsp_value(rsp_value[1]),
    .rsp_updated(rsp_updated[1]), .rsp_empty(rsp_empty[1]), .visited_count(visited_count[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and capture its response; g_lat counts cycles after the accept edge.
  task automatic do_cmd(input int u, input logic [1:0] op, input logic [3:0] idx, input logic [15:0] val);
    int w;
    w = 0;
    @(negedge clock);
    while (!cmd_ready[u] && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("cmd_ready_before_issue", 32'(cmd_ready[u]), 32'd1);
    cmd_valid[u] = 1'b1;
    cmd_op[u]    = op;
    cmd_index[u] = idx;
    cmd_value[u] = val;
    @(posedge clock);
    #1;
    cmd_valid[u] = 1'b0;
    g_lat = 0;
    g_got = 0;
    for (int k = 0; k < 20 && g_got == 0; k++) begin
      @(negedge clock);
      g_lat++;
      if (rsp_valid[u]) begin
        g_got   = 1;
        g_idx   = rsp_index[u];
        g_val   = rsp_value[u];
        g_upd   = rsp_updated[u];
        g_empty = rsp_empty[u];
      end
    end
    check("rsp_seen", 32'(g_got), 32'd1);
    @(negedge clock);
    check("rsp_one_pulse", 32'(rsp_valid[u]), 32'd0);
  endtask

  task automatic expect_rsp(input string tag, input int lat, input logic [3:0] idx,
                            input logic [15:0] val, input logic upd, input logic emp);
    check({tag, "_lat"}, 32'(g_lat), 32'(lat));
    check({tag, "_idx"}, 32'(g_idx), 32'(idx));
    check({tag, "_val"}, 32'(g_val), 32'(val));
    check({tag, "_upd"}, 32'(g_upd), 32'(upd));
    check({tag, "_empty"}, 32'(g_empty), 32'(emp));
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1; cmd_valid[u] = 1'b0; cmd_op[u] = 2'b00;
      cmd_index[u] = 4'd0; cmd_value[u] = 16'd0;
    end
    repeat (3) @(negedge clock);
    check("reset_ready", 32'(cmd_ready[0]), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("reset_rsp_value", 32'(rsp_value[0]), 32'd0);
    check("reset_rsp_index", 32'(rsp_index[0]), 32'd0);
    check("reset_vcount", 32'(visited_count[0]), 32'd0);
    reset[0] = 1'b0; reset[1] = 1'b0;
    @(negedge clock);
    check("ready_after_reset", 32'(cmd_ready[0]), 32'd1);

    // Case 1: INIT and READ (in range, unreached, out of range)
    do_cmd(0, 2'b00, 4'd3, 16'd0);     expect_rsp("a_init3", 1, 4'd3, 16'h0000, 1'b0, 1'b0);
    do_cmd(0, 2'b10, 4'd3, 16'd0);     expect_rsp("a_read3", 1, 4'd3, 16'h0000, 1'b0, 1'b0);
    do_cmd(0, 2'b10, 4'd5, 16'd0);     expect_rsp("a_read5", 1, 4'd5, 16'hFFFF, 1'b0, 1'b0);
    do_cmd(0, 2'b10, 4'd9, 16'd0);     expect_rsp("a_read9", 1, 4'd9, 16'hFFFF, 1'b0, 1'b0);

    // Case 2: RELAX strictness
    do_cmd(0, 2'b01, 4'd5, 16'd10);    expect_rsp("a_relax5_10", 1, 4'd5, 16'd10, 1'b1, 1'b0);
    do_cmd(0, 2'b01, 4'd5, 16'd12);    expect_rsp("a_relax5_12", 1, 4'd5, 16'd10, 1'b0, 1'b0);
    do_cmd(0, 2'b01, 4'd5, 16'd10);    expect_rsp("a_relax5_eq", 1, 4'd5, 16'd10, 1'b0, 1'b0);

    // Case 3: POP latency S+1=5, visited blocks relax
    do_cmd(0, 2'b11, 4'd0, 16'd0);     expect_rsp("a_pop1", 5, 4'd3, 16'd0, 1'b0, 1'b0);
    check("a_vcount1", 32'(visited_count[0]), 32'd1);
    do_cmd(0, 2'b01, 4'd3, 16'd0);     expect_rsp("a_relax_visited", 1, 4'd3, 16'd0, 1'b0, 1'b0);
    do_cmd(0, 2'b11, 4'd0, 16'd0);     expect_rsp("a_pop2", 5, 4'd5, 16'd10, 1'b0, 1'b0);
    check("a_vcount2", 32'(visited_count[0]), 32'd2);

    // Case 4: cross-chunk tie goes to lowest index
    do_cmd(0, 2'b00, 4'd0, 16'd0);     expect_rsp("a_init0", 1, 4'd0, 16'd0, 1'b0, 1'b0);
    check("a_vcount_init", 32'(visited_count[0]), 32'd0);
    do_cmd(0, 2'b11, 4'd0, 16'd0);     expect_rsp("a_pop_src", 5, 4'd0, 16'd0, 1'b0, 1'b0);
    do_cmd(0, 2'b01, 4'd6, 16'd7);     expect_rsp("a_relax6", 1, 4'd6, 16'd7, 1'b1, 1'b0);
    do_cmd(0, 2'b01, 4'd1, 16'd7);     expect_rsp("a_relax1", 1, 4'd1, 16'd7, 1'b1, 1'b0);
    do_cmd(0, 2'b11, 4'd0, 16'd0);     expect_rsp("a_pop_tie1", 5, 4'd1, 16'd7, 1'b0, 1'b0);
    do_cmd(0, 2'b11, 4'd0, 16'd0);     expect_rsp("a_pop_tie6", 5, 4'd6, 16'd7, 1'b0, 1'b0);
    check("a_vcount3", 32'(visited_count[0]), 32'd3);

    // Case 5: nothing reachable left
    do_cmd(0, 2'b11, 4'd0, 16'd0);     expect_rsp("a_pop_empty", 5, 4'd0, 16'hFFFF, 1'b0, 1'b1);
    check("a_vcount_empty", 32'(visited_count[0]), 32'd3);

    // Same-chunk tie (nodes 4,5 share chunk 2)
    do_cmd(0, 2'b00, 4'd7, 16'd0);     expect_rsp("a_init7", 1, 4'd7, 16'd0, 1'b0, 1'b0);
    do_cmd(0, 2'b11, 4'd0, 16'd0);     expect_rsp("a_pop7", 5, 4'd7, 16'd0, 1'b0, 1'b0);
    do_cmd(0, 2'b01, 4'd5, 16'd9);     expect_rsp("a_relax5_9", 1, 4'd5, 16'd9, 1'b1, 1'b0);
    do_cmd(0, 2'b01, 4'd4, 16'd9);     expect_rsp("a_relax4_9", 1, 4'd4, 16'd9, 1'b1, 1'b0);
    do_cmd(0, 2'b11, 4'd0, 16'd0);     expect_rsp("a_pop_tie4", 5, 4'd4, 16'd9, 1'b0, 1'b0);
    do_cmd(0, 2'b11, 4'd0, 16'd0);     expect_rsp("a_pop_tie5", 5, 4'd5, 16'd9, 1'b0, 1'b0);

    // Case 6: reset during SCAN aborts the pop
    do_cmd(0, 2'b00, 4'd2, 16'd0);     expect_rsp("a_init2", 1, 4'd2, 16'd0, 1'b0, 1'b0);
    @(negedge clock);
    cmd_valid[0] = 1'b1; cmd_op[0] = 2'b11; cmd_index[0] = 4'd0;
    @(posedge clock);
    #1;
    cmd_valid[0] = 1'b0;
    @(negedge clock);
    check("a_scan_busy", 32'(cmd_ready[0]), 32'd0);
    reset[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("a_abort_no_rsp", 32'(rsp_valid[0]), 32'd0);
    end
    reset[0] = 1'b0;
    @(negedge clock);
    check("a_ready_after_abort", 32'(cmd_ready[0]), 32'd1);
    check("a_abort_no_rsp_after", 32'(rsp_valid[0]), 32'd0);
    check("a_vcount_abort", 32'(visited_count[0]), 32'd0);
    for (int n = 0; n < 8; n++) begin
      do_cmd(0, 2'b10, 4'(n), 16'd0);
      check("a_read_after_abort", 32'(g_val), 32'h0000FFFF);
    end

    // Unit 1: MAX_NODES=7, LANES=3, POP latency 4
    do_cmd(1, 2'b00, 4'd3, 16'd0);     expect_rsp("b_init3", 1, 4'd3, 16'd0, 1'b0, 1'b0);
    do_cmd(1, 2'b01, 4'd5, 16'd10);    expect_rsp("b_relax5", 1, 4'd5, 16'd10, 1'b1, 1'b0);
    do_cmd(1, 2'b11, 4'd0, 16'd0);     expect_rsp("b_pop1", 4, 4'd3, 16'd0, 1'b0, 1'b0);
    check("b_vcount1", 32'(visited_count[1]), 32'd1);
    do_cmd(1, 2'b01, 4'd3, 16'd0);     expect_rsp("b_relax_visited", 1, 4'd3, 16'd0, 1'b0, 1'b0);
    do_cmd(1, 2'b11, 4'd0, 16'd0);     expect_rsp("b_pop2", 4, 4'd5, 16'd10, 1'b0, 1'b0);
    do_cmd(1, 2'b00, 4'd0, 16'd0);     expect_rsp("b_init0", 1, 4'd0, 16'd0, 1'b0, 1'b0);
    do_cmd(1, 2'b11, 4'd0, 16'd0);     expect_rsp("b_pop_src", 4, 4'd0, 16'd0, 1'b0, 1'b0);
    do_cmd(1, 2'b01, 4'd6, 16'd7);     expect_rsp("b_relax6", 1, 4'd6, 16'd7, 1'b1, 1'b0);
    do_cmd(1, 2'b01, 4'd1, 16'd7);     expect_rsp("b_relax1", 1, 4'd1, 16'd7, 1'b1, 1'b0);
    do_cmd(1, 2'b10, 4'd7, 16'd0);     expect_rsp("b_read7_oor", 1, 4'd7, 16'hFFFF, 1'b0, 1'b0);
    do_cmd(1, 2'b01, 4'd7, 16'd5);     expect_rsp("b_relax7_oor", 1, 4'd7, 16'hFFFF, 1'b0, 1'b0);
    do_cmd(1, 2'b11, 4'd0, 16'd0);     expect_rsp("b_pop_tie1", 4, 4'd1, 16'd7, 1'b0, 1'b0);
    do_cmd(1, 2'b11, 4'd0, 16'd0);     expect_rsp("b_pop_tie6", 4, 4'd6, 16'd7, 1'b0, 1'b0);
    do_cmd(1, 2'b11, 4'd0, 16'd0);     expect_rsp("b_pop_empty", 4, 4'd0, 16'hFFFF, 1'b0, 1'b1);
    check("b_vcount_end", 32'(visited_count[1]), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
